// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: FSM state encoding and
// oversampling constants used by the receiver and its bench.
package uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } rx_state_t;

    localparam int OVERSAMPLE  = 16;
    localparam int START_MID   = 7;
    localparam int DEF_NB_DATA = 8;
    localparam int DEF_SB_TICK = 16;

endpackage

// File: rtl/rx_sync_module.sv
// Two-flop synchronizer for the asynchronous RX line; both flops reset to the
// idle level so a reset never looks like a start bit.
module rx_sync_module (
    input  logic clk,
    input  logic reset,
    input  logic rx,
    output logic rx_s
);

    logic meta;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            meta <= rx;
            rx_s <= meta;
        end
    end

endmodule

// File: rtl/uart_rx_module.sv
// 16x oversampling UART receiver: detects the start edge, verifies it at
// mid-bit, samples each data bit at its centre and reports the stop-bit level.
module uart_rx_module
    import uart_pkg::*;
#(
    parameter int NB_DATA         = DEF_NB_DATA,
    parameter int SB_TICK         = DEF_SB_TICK,
    parameter int NB_TICK_COUNTER = 5
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_tick,
    input  logic               i_rx,
    output logic               o_rx_done_tick,
    output logic [NB_DATA-1:0] o_data,
    output logic               o_frame_err
);

    localparam int NB_BIT_COUNTER = $clog2(NB_DATA);
    localparam int MAX_TICK       = (SB_TICK > OVERSAMPLE) ? SB_TICK : OVERSAMPLE;

    localparam logic [NB_TICK_COUNTER-1:0] S_START_MID = NB_TICK_COUNTER'(START_MID);
    localparam logic [NB_TICK_COUNTER-1:0] S_BIT_END   = NB_TICK_COUNTER'(OVERSAMPLE - 1);
    localparam logic [NB_TICK_COUNTER-1:0] S_STOP_END  = NB_TICK_COUNTER'(SB_TICK - 1);
    localparam logic [NB_BIT_COUNTER-1:0]  N_LAST      = NB_BIT_COUNTER'(NB_DATA - 1);

    if (NB_DATA < 5 || NB_DATA > 9 || (2 ** NB_TICK_COUNTER) < MAX_TICK) begin : g_param_check
        $error("uart_rx_module: NB_DATA must be 5..9 and NB_TICK_COUNTER must hold SB_TICK-1");
    end

    logic rx_s;

    rx_sync_module u_sync (
        .clk   (i_clk),
        .reset (i_reset),
        .rx    (i_rx),
        .rx_s  (rx_s)
    );

    rx_state_t                  state, state_next;
    logic [NB_TICK_COUNTER-1:0] s, s_next;
    logic [NB_BIT_COUNTER-1:0]  n, n_next;
    logic [NB_DATA-1:0]         b, b_next;
    logic [NB_DATA-1:0]         data_next;
    logic                       frame_err_next;
    logic                       done_next;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state          <= ST_IDLE;
            s              <= '0;
            n              <= '0;
            b              <= '0;
            o_data         <= '0;
            o_frame_err    <= 1'b0;
            o_rx_done_tick <= 1'b0;
        end else begin
            state          <= state_next;
            s              <= s_next;
            n              <= n_next;
            b              <= b_next;
            o_data         <= data_next;
            o_frame_err    <= frame_err_next;
            o_rx_done_tick <= done_next;
        end
    end

    // Counters advance only on ticks; IDLE reacts to the edge without one so
    // a tick coinciding with the edge is never counted.
    always_comb begin
        state_next     = state;
        s_next         = s;
        n_next         = n;
        b_next         = b;
        data_next      = o_data;
        frame_err_next = o_frame_err;
        done_next      = 1'b0;

        case (state)
            ST_IDLE: begin
                if (!rx_s) begin
                    state_next = ST_START;
                    s_next     = '0;
                end
            end
            ST_START: begin
                if (i_tick) begin
                    if (s == S_START_MID) begin
                        s_next = '0;
                        if (!rx_s) begin
                            state_next = ST_DATA;
                            n_next     = '0;
                        end else begin
                            state_next = ST_IDLE;
                        end
                    end else begin
                        s_next = s + 1'b1;
                    end
                end
            end
            ST_DATA: begin
                if (i_tick) begin
                    if (s == S_BIT_END) begin
                        s_next = '0;
                        b_next = {rx_s, b[NB_DATA-1:1]};
                        if (n == N_LAST) begin
                            state_next = ST_STOP;
                        end else begin
                            n_next = n + 1'b1;
                        end
                    end else begin
                        s_next = s + 1'b1;
                    end
                end
            end
            ST_STOP: begin
                if (i_tick) begin
                    if (s == S_STOP_END) begin
                        state_next     = ST_IDLE;
                        data_next      = b;
                        frame_err_next = ~rx_s;
                        done_next      = 1'b1;
                    end else begin
                        s_next = s + 1'b1;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_uart_rx_module.sv
// Directed and randomized frames against two receiver configurations; expected
// words, error flags and strobe tick positions come from frame-level rules.
module tb_uart_rx_module;
    import uart_pkg::*;

    typedef struct {
        logic [8:0]  data;
        logic        err;
        int unsigned t;
    } ev_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset, tick, rx, rx7;
    logic       done8, err8, done7, err7;
    logic [7:0] data8;
    logic [6:0] data7;

    uart_rx_module #(.NB_DATA(8), .SB_TICK(16), .NB_TICK_COUNTER(5)) dut (
        .i_clk(clk), .i_reset(reset), .i_tick(tick), .i_rx(rx),
        .o_rx_done_tick(done8), .o_data(data8), .o_frame_err(err8)
    );

    uart_rx_module #(.NB_DATA(7), .SB_TICK(32), .NB_TICK_COUNTER(5)) dut7 (
        .i_clk(clk), .i_reset(reset), .i_tick(tick), .i_rx(rx7),
        .o_rx_done_tick(done7), .o_data(data7), .o_frame_err(err7)
    );

    int          total = 0;
    int          bad   = 0;
    int unsigned tick_cnt = 0;
    logic [1:0]  phase = 2'd0;
    logic        rx_n = 1'b1, rx7_n = 1'b1, reset_n = 1'b1;
    logic        prev8 = 1'b0, prev7 = 1'b0;
    ev_t         obs8[$], obs7[$], exp8[$], exp7[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Strobes are captured just after the edge that registers them.
    always @(posedge clk) begin
        #1;
        if (done8) begin
            check("done8_after_tick", 32'(tick), 32'd1);
            check("done8_one_cycle", 32'(prev8), 32'd0);
            obs8.push_back('{data: 9'(data8), err: err8, t: tick_cnt});
        end
        if (done7) begin
            check("done7_after_tick", 32'(tick), 32'd1);
            check("done7_one_cycle", 32'(prev7), 32'd0);
            obs7.push_back('{data: 9'(data7), err: err7, t: tick_cnt});
        end
        prev8 <= done8;
        prev7 <= done7;
    end

    task automatic step();
        @(negedge clk);
        reset = reset_n;
        rx    = rx_n;
        rx7   = rx7_n;
        tick  = (phase == 2'd3);
        if (phase == 2'd3) tick_cnt++;
        phase++;
    endtask

    task automatic steps(input int cnt);
        for (int i = 0; i < cnt; i++) step();
    endtask

    task automatic drive(input bit sel7, input logic v);
        if (sel7) rx7_n = v;
        else      rx_n  = v;
    endtask

    task automatic align();
        while (phase != 2'd0) step();
    endtask

    // A bad stop bit is held low only past its sampling point, then the line idles.
    task automatic send_frame(input bit sel7, input logic [8:0] d, input int nb,
                              input int nstop, input bit stop_ok);
        ev_t e;
        align();
        e.data = d & ((9'd1 << nb) - 9'd1);
        e.err  = !stop_ok;
        e.t    = tick_cnt + 8 + 16 * nb + 16 * nstop;
        if (sel7) exp7.push_back(e);
        else      exp8.push_back(e);
        drive(sel7, 1'b0);
        steps(64);
        for (int k = 0; k < nb; k++) begin
            drive(sel7, d[k]);
            steps(64);
        end
        if (stop_ok) begin
            drive(sel7, 1'b1);
            steps(64 * nstop);
        end else begin
            drive(sel7, 1'b0);
            steps(40);
            drive(sel7, 1'b1);
            steps(64 * nstop - 40);
        end
    endtask

    task automatic compare(input bit sel7);
        ev_t e, o;
        if (sel7) check("frames7", obs7.size(), exp7.size());
        else      check("frames8", obs8.size(), exp8.size());
        while (sel7 ? (exp7.size() > 0 && obs7.size() > 0) : (exp8.size() > 0 && obs8.size() > 0)) begin
            if (sel7) begin
                e = exp7.pop_front();
                o = obs7.pop_front();
            end else begin
                e = exp8.pop_front();
                o = obs8.pop_front();
            end
            check(sel7 ? "data7" : "data8", 32'(o.data), 32'(e.data));
            check(sel7 ? "err7" : "err8", 32'(o.err), 32'(e.err));
            check(sel7 ? "strobe_tick7" : "strobe_tick8", o.t, e.t);
        end
        exp7.delete(); obs7.delete();
        exp8.delete(); obs8.delete();
    endtask

    initial begin
        logic [8:0] d;
        bit         ok;

        reset = 1'b1; tick = 1'b0; rx = 1'b1; rx7 = 1'b1;
        steps(4);
        @(posedge clk); #1;
        check("reset_done8", 32'(done8), 32'd0);
        check("reset_data8", 32'(data8), 32'd0);
        check("reset_err8", 32'(err8), 32'd0);
        check("reset_data7", 32'(data7), 32'd0);
        check("reset_err7", 32'(err7), 32'd0);
        reset_n = 1'b0;
        steps(40);

        send_frame(1'b0, 9'hA5, 8, 1, 1'b1);
        steps(64);
        compare(1'b0);

        send_frame(1'b0, 9'h3C, 8, 1, 1'b0);
        steps(64);
        compare(1'b0);

        // Five-tick low glitch: counted in START, dropped at the eighth tick.
        align();
        drive(1'b0, 1'b0);
        steps(20);
        drive(1'b0, 1'b1);
        steps(11);
        @(posedge clk); #1;
        check("glitch_counting", 32'(dut.state), 32'(ST_START));
        step();
        @(posedge clk); #1;
        check("glitch_back_idle", 32'(dut.state), 32'(ST_IDLE));
        steps(200);
        check("glitch_no_done", obs8.size(), 0);

        // Reset halfway through the data bits of 0x81.
        align();
        d = 9'h081;
        drive(1'b0, 1'b0);
        steps(64);
        for (int k = 0; k < 4; k++) begin
            drive(1'b0, d[k]);
            steps(64);
        end
        drive(1'b0, d[4]);
        steps(32);
        reset_n = 1'b1;
        rx_n    = 1'b1;
        step();
        @(posedge clk); #1;
        check("midreset_done", 32'(done8), 32'd0);
        check("midreset_data", 32'(data8), 32'd0);
        check("midreset_err", 32'(err8), 32'd0);
        reset_n = 1'b0;
        steps(64 * 12);
        check("midreset_no_done", obs8.size(), 0);

        send_frame(1'b0, 9'h81, 8, 1, 1'b1);
        send_frame(1'b0, 9'hFF, 8, 1, 1'b1);
        steps(64);
        compare(1'b0);

        send_frame(1'b0, 9'h00, 8, 1, 1'b1);
        send_frame(1'b0, 9'hFF, 8, 1, 1'b1);
        send_frame(1'b0, 9'h55, 8, 1, 1'b1);
        steps(64);
        compare(1'b0);

        repeat (6) begin
            d  = 9'($urandom_range(0, 255));
            ok = ($urandom_range(0, 3) != 0);
            send_frame(1'b0, d, 8, 1, ok);
            steps(64 * $urandom_range(0, 2));
        end
        steps(64);
        compare(1'b0);

        send_frame(1'b1, 9'h02A, 7, 2, 1'b1);
        steps(64);
        compare(1'b1);
        compare(1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
